// File: rtl/utf8_pkg.sv
// Shared types and constants for the UTF-8 byte-to-scalar front end.
// Lead-byte classification lives here so every stage agrees on byte ranges.
package utf8_pkg;

  localparam logic [20:0] REPLACEMENT = 21'h00FFFD;

  typedef enum logic [2:0] {
    CLASS_ASCII,
    CLASS_LEAD2,
    CLASS_LEAD3,
    CLASS_LEAD4,
    CLASS_CONT,
    CLASS_INVALID
  } byte_class_e;

  typedef enum logic {
    DEC_LEAD,
    DEC_CONT
  } dec_state_e;

  // C0/C1 and F5-FF can only start overlong or out-of-range sequences.
  function automatic byte_class_e classify(input logic [7:0] b);
    byte_class_e c;
    if (b <= 8'h7F)                    c = CLASS_ASCII;
    else if (b <= 8'hBF)               c = CLASS_CONT;
    else if (b >= 8'hC2 && b <= 8'hDF) c = CLASS_LEAD2;
    else if (b >= 8'hE0 && b <= 8'hEF) c = CLASS_LEAD3;
    else if (b >= 8'hF0 && b <= 8'hF4) c = CLASS_LEAD4;
    else                               c = CLASS_INVALID;
    return c;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO, write-to-head latency 1 cycle; head_dat is the registered head entry.
// A write while full is accepted only if a read frees a slot in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_vld,
  input  logic [7:0] wr_dat,
  input  logic       rd_vld,
  output logic [7:0] head_dat,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        wr_en, rd_en;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign rd_en = rd_vld & ~empty;
  assign wr_en = wr_vld & (~full | rd_en);
  assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat;
  end

endmodule

// File: rtl/utf8_decoder.sv
// UTF-8 decoder: buffered bytes in, 21-bit scalars out; ASCII strobe-to-available is 2 cycles.
// Scalars wait in a one-entry slot until ready_n is low; malformed input becomes REPLACEMENT.
module utf8_decoder #(
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [20:0] REPLACEMENT = utf8_pkg::REPLACEMENT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        overflow,
  output logic [20:0] unicode,
  output logic        unicode_available,
  input  logic        ready_n,
  output logic        decode_error
);

  import utf8_pkg::*;

  logic [7:0]  head_dat;
  logic        fifo_full, fifo_empty, pop;
  byte_class_e head_class;

  dec_state_e  state_q, state_d;
  logic [1:0]  need_q, need_d;
  logic [1:0]  len_q, len_d;
  logic [20:0] acc_q, acc_d;
  logic [20:0] out_dat_q, out_dat_d;
  logic        out_vld_q, out_vld_d;
  logic        decode_error_q, decode_error_d;
  logic        overflow_q, overflow_d;

  logic        slot_free, load, load_err, seq_ok;
  logic [20:0] load_dat, acc_shift;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_vld   (byte_valid),
    .wr_dat   (byte_in),
    .rd_vld   (pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign head_class = classify(head_dat);
  assign slot_free  = ~out_vld_q | ~ready_n;
  assign acc_shift  = {acc_q[14:0], head_dat[5:0]};

  // len_q holds the continuation count of the sequence in flight (1..3).
  always_comb begin
    seq_ok = 1'b1;
    if (len_q == 2'd2)
      seq_ok = (acc_shift >= 21'h000800) && !(acc_shift >= 21'h00D800 && acc_shift <= 21'h00DFFF);
    else if (len_q == 2'd3)
      seq_ok = (acc_shift >= 21'h010000) && (acc_shift <= 21'h10FFFF);
  end

  always_comb begin
    state_d  = state_q;
    need_d   = need_q;
    len_d    = len_q;
    acc_d    = acc_q;
    pop      = 1'b0;
    load     = 1'b0;
    load_err = 1'b0;
    load_dat = '0;
    if (!fifo_empty) begin
      case (state_q)
        DEC_LEAD: begin
          case (head_class)
            CLASS_ASCII: begin
              if (slot_free) begin
                load     = 1'b1;
                load_dat = {13'd0, head_dat};
                pop      = 1'b1;
              end
            end
            CLASS_LEAD2: begin
              need_d  = 2'd1;
              len_d   = 2'd1;
              acc_d   = {16'd0, head_dat[4:0]};
              pop     = 1'b1;
              state_d = DEC_CONT;
            end
            CLASS_LEAD3: begin
              need_d  = 2'd2;
              len_d   = 2'd2;
              acc_d   = {17'd0, head_dat[3:0]};
              pop     = 1'b1;
              state_d = DEC_CONT;
            end
            CLASS_LEAD4: begin
              need_d  = 2'd3;
              len_d   = 2'd3;
              acc_d   = {18'd0, head_dat[2:0]};
              pop     = 1'b1;
              state_d = DEC_CONT;
            end
            default: begin
              if (slot_free) begin
                load     = 1'b1;
                load_dat = REPLACEMENT;
                load_err = 1'b1;
                pop      = 1'b1;
              end
            end
          endcase
        end
        DEC_CONT: begin
          if (head_class == CLASS_CONT) begin
            if (need_q != 2'd1) begin
              acc_d  = acc_shift;
              need_d = need_q - 2'd1;
              pop    = 1'b1;
            end else if (slot_free) begin
              acc_d    = acc_shift;
              need_d   = 2'd0;
              pop      = 1'b1;
              load     = 1'b1;
              load_dat = seq_ok ? acc_shift : REPLACEMENT;
              load_err = ~seq_ok;
              state_d  = DEC_LEAD;
            end
          end else if (slot_free) begin
            // Leave the offending byte at the head so it restarts as a lead.
            load     = 1'b1;
            load_dat = REPLACEMENT;
            load_err = 1'b1;
            need_d   = 2'd0;
            state_d  = DEC_LEAD;
          end
        end
        default: state_d = DEC_LEAD;
      endcase
    end
  end

  always_comb begin
    out_vld_d      = load | (out_vld_q & ready_n);
    out_dat_d      = load ? load_dat : out_dat_q;
    decode_error_d = load_err;
    overflow_d     = overflow_q | (byte_valid & fifo_full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= DEC_LEAD;
      need_q         <= '0;
      len_q          <= '0;
      acc_q          <= '0;
      out_dat_q      <= '0;
      out_vld_q      <= 1'b0;
      decode_error_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      need_q         <= need_d;
      len_q          <= len_d;
      acc_q          <= acc_d;
      out_dat_q      <= out_dat_d;
      out_vld_q      <= out_vld_d;
      decode_error_q <= decode_error_d;
      overflow_q     <= overflow_d;
    end
  end

  assign unicode           = out_dat_q;
  assign unicode_available = out_vld_q & ~ready_n;
  assign decode_error      = decode_error_q;
  assign overflow          = overflow_q;

endmodule
